// File: rtl/credit_pkg.sv
// Shared coin codes, refund FSM states and default money constants for the credit stage.
package credit_pkg;

  localparam logic [1:0] COIN_NICKEL  = 2'd0;
  localparam logic [1:0] COIN_DIME    = 2'd1;
  localparam logic [1:0] COIN_QUARTER = 2'd2;
  localparam logic [1:0] COIN_DOLLAR  = 2'd3;

  localparam int DEFAULT_MAX_CREDIT  = 250;
  localparam int DEFAULT_VAL_NICKEL  = 5;
  localparam int DEFAULT_VAL_DIME    = 10;
  localparam int DEFAULT_VAL_QUARTER = 25;
  localparam int DEFAULT_VAL_DOLLAR  = 100;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECT   = 2'd1,
    WAIT_ACK = 2'd2
  } refund_state_t;

endpackage

// File: rtl/coin_value_lut.sv
// Maps a 2-bit coin code to its value in cents.
module coin_value_lut
  import credit_pkg::*;
#(
  parameter int VAL_NICKEL  = DEFAULT_VAL_NICKEL,
  parameter int VAL_DIME    = DEFAULT_VAL_DIME,
  parameter int VAL_QUARTER = DEFAULT_VAL_QUARTER,
  parameter int VAL_DOLLAR  = DEFAULT_VAL_DOLLAR
) (
  input  logic [1:0] code,
  output logic [7:0] value
);

  always_comb begin
    value = VAL_NICKEL[7:0];
    case (code)
      COIN_NICKEL:  value = VAL_NICKEL[7:0];
      COIN_DIME:    value = VAL_DIME[7:0];
      COIN_QUARTER: value = VAL_QUARTER[7:0];
      COIN_DOLLAR:  value = VAL_DOLLAR[7:0];
      default:      value = VAL_NICKEL[7:0];
    endcase
  end

endmodule

// File: rtl/credit_accumulator.sv
// Running customer credit: accepts coins, loads post-purchase credit from the FSM,
// and pays a refund back largest coin first over a valid/ack handshake.
module credit_accumulator
  import credit_pkg::*;
#(
  parameter int MAX_CREDIT  = DEFAULT_MAX_CREDIT,
  parameter int VAL_NICKEL  = DEFAULT_VAL_NICKEL,
  parameter int VAL_DIME    = DEFAULT_VAL_DIME,
  parameter int VAL_QUARTER = DEFAULT_VAL_QUARTER,
  parameter int VAL_DOLLAR  = DEFAULT_VAL_DOLLAR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       update_total_money,
  input  logic [7:0] remaining_money,
  input  logic       refund_req,
  input  logic       change_ack,
  output logic [7:0] total_money,
  output logic       coin_reject,
  output logic       change_valid,
  output logic [1:0] change_type,
  output logic       refund_busy,
  output logic       residual_lost
);

  localparam logic [8:0] MAX9      = MAX_CREDIT[8:0];
  localparam logic [7:0] V_NICKEL  = VAL_NICKEL[7:0];
  localparam logic [7:0] V_DIME    = VAL_DIME[7:0];
  localparam logic [7:0] V_QUARTER = VAL_QUARTER[7:0];
  localparam logic [7:0] V_DOLLAR  = VAL_DOLLAR[7:0];

  refund_state_t state, state_next;

  logic [7:0] coin_value;
  logic [7:0] change_value;
  logic [7:0] base;
  logic [8:0] sum;
  logic [7:0] total_next;
  logic       reject_next;
  logic       valid_next;
  logic [1:0] type_next;
  logic       residual_next;

  coin_value_lut #(
    .VAL_NICKEL (VAL_NICKEL),
    .VAL_DIME   (VAL_DIME),
    .VAL_QUARTER(VAL_QUARTER),
    .VAL_DOLLAR (VAL_DOLLAR)
  ) u_coin_lut (
    .code (coin_type),
    .value(coin_value)
  );

  coin_value_lut #(
    .VAL_NICKEL (VAL_NICKEL),
    .VAL_DIME   (VAL_DIME),
    .VAL_QUARTER(VAL_QUARTER),
    .VAL_DOLLAR (VAL_DOLLAR)
  ) u_change_lut (
    .code (change_type),
    .value(change_value)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (refund_req && total_money != 8'd0) state_next = SELECT;
      SELECT:   state_next = (total_money >= V_NICKEL) ? WAIT_ACK : IDLE;
      WAIT_ACK: if (change_ack) state_next = SELECT;
      default:  state_next = IDLE;
    endcase
  end

  // An update from the FSM is applied before the coin, so the sum starts from the loaded credit.
  assign base = update_total_money ? remaining_money : total_money;
  assign sum  = {1'b0, base} + {1'b0, coin_value};

  always_comb begin
    total_next    = total_money;
    reject_next   = 1'b0;
    valid_next    = change_valid;
    type_next     = change_type;
    residual_next = 1'b0;
    case (state)
      IDLE: begin
        total_next = base;
        if (coin_valid) begin
          if (sum <= MAX9) total_next  = sum[7:0];
          else             reject_next = 1'b1;
        end
      end
      SELECT: begin
        reject_next = coin_valid;
        if (total_money >= V_DOLLAR) begin
          type_next  = COIN_DOLLAR;
          valid_next = 1'b1;
        end else if (total_money >= V_QUARTER) begin
          type_next  = COIN_QUARTER;
          valid_next = 1'b1;
        end else if (total_money >= V_DIME) begin
          type_next  = COIN_DIME;
          valid_next = 1'b1;
        end else if (total_money >= V_NICKEL) begin
          type_next  = COIN_NICKEL;
          valid_next = 1'b1;
        end else if (total_money != 8'd0) begin
          total_next    = 8'd0;
          residual_next = 1'b1;
        end
      end
      WAIT_ACK: begin
        reject_next = coin_valid;
        if (change_ack) begin
          total_next = total_money - change_value;
          valid_next = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_money   <= 8'd0;
      coin_reject   <= 1'b0;
      change_valid  <= 1'b0;
      change_type   <= COIN_NICKEL;
      refund_busy   <= 1'b0;
      residual_lost <= 1'b0;
    end else begin
      total_money   <= total_next;
      coin_reject   <= reject_next;
      change_valid  <= valid_next;
      change_type   <= type_next;
      refund_busy   <= (state_next != IDLE);
      residual_lost <= residual_next;
    end
  end

endmodule

// File: tb/tb_credit_accumulator.sv
// Directed, self-checking bench for credit_accumulator with hand-computed expectations.
module tb_credit_accumulator;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       update_total_money;
  logic [7:0] remaining_money;
  logic       refund_req;
  logic       change_ack;
  logic [7:0] total_money;
  logic       coin_reject;
  logic       change_valid;
  logic [1:0] change_type;
  logic       refund_busy;
  logic       residual_lost;

  int n_compared   = 0;
  int n_mismatched = 0;

  credit_accumulator dut (
    .clk               (clk),
    .reset             (reset),
    .coin_valid        (coin_valid),
    .coin_type         (coin_type),
    .update_total_money(update_total_money),
    .remaining_money   (remaining_money),
    .refund_req        (refund_req),
    .change_ack        (change_ack),
    .total_money       (total_money),
    .coin_reject       (coin_reject),
    .change_valid      (change_valid),
    .change_type       (change_type),
    .refund_busy       (refund_busy),
    .residual_lost     (residual_lost)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_credit(input logic [7:0] amount);
    update_total_money = 1'b1;
    remaining_money    = amount;
    tick();
    update_total_money = 1'b0;
    remaining_money    = 8'd0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (change_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; coin_valid = 1'b0; coin_type = 2'd0; update_total_money = 1'b0;
    remaining_money = 8'd0; refund_req = 1'b0; change_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_compared++;
    if ({total_money, coin_reject, change_valid, change_type, refund_busy, residual_lost} !== 14'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_state: got total=%0d rej=%b cv=%b ct=%0d busy=%b res=%b, want all zero",
               total_money, coin_reject, change_valid, change_type, refund_busy, residual_lost);
    end
  endtask

  task automatic test_coins();
    logic [1:0] types [3];
    logic [7:0] exp   [3];
    types = '{2'd2, 2'd2, 2'd3};
    exp   = '{8'd25, 8'd50, 8'd150};
    for (int i = 0; i < 3; i++) begin
      coin_valid = 1'b1;
      coin_type  = types[i];
      tick();
      n_compared++;
      if (total_money !== exp[i] || coin_reject !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL coin_credit[%0d]: got total=%0d rej=%b, want total=%0d rej=0",
                 i, total_money, coin_reject, exp[i]);
      end
    end
    coin_valid = 1'b0;
  endtask

  task automatic test_overflow();
    load_credit(8'd200);
    n_compared++;
    if (total_money !== 8'd200) begin
      n_mismatched++;
      $display("[TB] FAIL load_200: got %0d, want 200", total_money);
    end
    coin_valid = 1'b1; coin_type = 2'd3;
    tick();
    coin_valid = 1'b0;
    n_compared++;
    if (coin_reject !== 1'b1 || total_money !== 8'd200) begin
      n_mismatched++;
      $display("[TB] FAIL overflow_reject: got rej=%b total=%0d, want rej=1 total=200", coin_reject, total_money);
    end
    tick();
    n_compared++;
    if (coin_reject !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reject_one_cycle: got rej=%b, want 0", coin_reject);
    end
    coin_valid = 1'b1; coin_type = 2'd2;
    tick();
    coin_valid = 1'b0;
    n_compared++;
    if (total_money !== 8'd225 || coin_reject !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL quarter_to_225: got total=%0d rej=%b, want total=225 rej=0", total_money, coin_reject);
    end
    // 225 + 25 lands exactly on the limit and must be accepted.
    coin_valid = 1'b1; coin_type = 2'd2;
    tick();
    coin_valid = 1'b0;
    n_compared++;
    if (total_money !== 8'd250 || coin_reject !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL limit_250: got total=%0d rej=%b, want total=250 rej=0", total_money, coin_reject);
    end
  endtask

  task automatic test_update_and_coin();
    load_credit(8'd150);
    update_total_money = 1'b1; remaining_money = 8'd65;
    coin_valid = 1'b1; coin_type = 2'd1;
    tick();
    update_total_money = 1'b0; coin_valid = 1'b0;
    n_compared++;
    if (total_money !== 8'd75 || coin_reject !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL update_plus_dime: got total=%0d rej=%b, want total=75 rej=0", total_money, coin_reject);
    end
  endtask

  task automatic test_refund_full();
    logic [1:0] types  [4];
    logic [7:0] totals [4];
    bit ok;
    types  = '{2'd3, 2'd2, 2'd1, 2'd0};
    totals = '{8'd40, 8'd15, 8'd5, 8'd0};
    load_credit(8'd140);
    refund_req = 1'b1;
    tick();
    refund_req = 1'b0;
    n_compared++;
    if (refund_busy !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL refund_start_busy: got %b, want 1", refund_busy);
    end
    for (int i = 0; i < 4; i++) begin
      wait_valid(ok);
      n_compared++;
      if (!ok) begin
        n_mismatched++;
        $display("[TB] FAIL refund140_valid_timeout[%0d]: got change_valid=0, want 1 within 10 cycles", i);
      end
      n_compared++;
      if (change_type !== types[i]) begin
        n_mismatched++;
        $display("[TB] FAIL refund140_type[%0d]: got %0d, want %0d", i, change_type, types[i]);
      end
      tick(); tick();
      n_compared++;
      if (change_valid !== 1'b1 || change_type !== types[i]) begin
        n_mismatched++;
        $display("[TB] FAIL refund140_hold[%0d]: got cv=%b ct=%0d, want cv=1 ct=%0d", i, change_valid, change_type, types[i]);
      end
      change_ack = 1'b1;
      tick();
      change_ack = 1'b0;
      n_compared++;
      if (total_money !== totals[i] || change_valid !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL refund140_total[%0d]: got total=%0d cv=%b, want total=%0d cv=0",
                 i, total_money, change_valid, totals[i]);
      end
    end
    tick();
    n_compared++;
    if (refund_busy !== 1'b0 || total_money !== 8'd0 || residual_lost !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL refund140_end: got busy=%b total=%0d res=%b, want busy=0 total=0 res=0",
               refund_busy, total_money, residual_lost);
    end
    refund_req = 1'b1;
    tick();
    refund_req = 1'b0;
    n_compared++;
    if (refund_busy !== 1'b0 || change_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL refund_zero_ignored: got busy=%b cv=%b, want busy=0 cv=0", refund_busy, change_valid);
    end
  endtask

  task automatic test_refund_residual();
    logic [1:0] types  [3];
    logic [7:0] totals [3];
    bit ok;
    types  = '{2'd2, 2'd2, 2'd1};
    totals = '{8'd38, 8'd13, 8'd3};
    load_credit(8'd63);
    refund_req = 1'b1;
    tick();
    refund_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_valid(ok);
      n_compared++;
      if (!ok || change_type !== types[i]) begin
        n_mismatched++;
        $display("[TB] FAIL refund63_offer[%0d]: got cv=%b ct=%0d, want cv=1 ct=%0d", i, change_valid, change_type, types[i]);
      end
      change_ack = 1'b1;
      tick();
      change_ack = 1'b0;
      n_compared++;
      if (total_money !== totals[i]) begin
        n_mismatched++;
        $display("[TB] FAIL refund63_total[%0d]: got %0d, want %0d", i, total_money, totals[i]);
      end
    end
    tick();
    n_compared++;
    if (residual_lost !== 1'b1 || total_money !== 8'd0 || refund_busy !== 1'b0 || change_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL residual_clear: got res=%b total=%0d busy=%b cv=%b, want res=1 total=0 busy=0 cv=0",
               residual_lost, total_money, refund_busy, change_valid);
    end
    tick();
    n_compared++;
    if (residual_lost !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL residual_one_cycle: got %b, want 0", residual_lost);
    end
  endtask

  task automatic test_busy_and_reset();
    bit ok;
    load_credit(8'd100);
    refund_req = 1'b1;
    tick();
    refund_req = 1'b0;
    wait_valid(ok);
    n_compared++;
    if (!ok || change_type !== 2'd3) begin
      n_mismatched++;
      $display("[TB] FAIL busy_offer: got cv=%b ct=%0d, want cv=1 ct=3", change_valid, change_type);
    end
    coin_valid = 1'b1; coin_type = 2'd1;
    update_total_money = 1'b1; remaining_money = 8'd7;
    tick();
    coin_valid = 1'b0; update_total_money = 1'b0;
    n_compared++;
    if (coin_reject !== 1'b1 || total_money !== 8'd100 || change_type !== 2'd3 || change_valid !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL busy_ignore: got rej=%b total=%0d ct=%0d cv=%b, want rej=1 total=100 ct=3 cv=1",
               coin_reject, total_money, change_type, change_valid);
    end
    #1;
    reset = 1'b1;
    #2;
    n_compared++;
    if (total_money !== 8'd0 || change_valid !== 1'b0 || refund_busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset: got total=%0d cv=%b busy=%b, want total=0 cv=0 busy=0",
               total_money, change_valid, refund_busy);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_coins();
    test_overflow();
    test_update_and_coin();
    test_refund_full();
    test_refund_residual();
    test_busy_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
